// File: rtl/fft_frame_serializer.sv
// Captures 16-bin FFT frames into a two-bank ping-pong buffer and replays them one bin per beat.
// Optional per-frame peak-bin detector enabled with `define FFT_SER_PEAK_EN.
module fft_frame_serializer #(
    parameter int unsigned DEPTH_BANKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_d,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        overflow,
    output logic [7:0]  frames_out
`ifdef FFT_SER_PEAK_EN
    ,
    output logic [3:0]  peak_idx,
    output logic        peak_valid
`endif
);

    localparam int unsigned NBINS = 16;
    localparam int unsigned IDXW  = 4;
    localparam int unsigned WORDW = 32;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [WORDW-1:0]         r_mem [DEPTH_BANKS][NBINS];
    logic [DEPTH_BANKS-1:0]   r_full;
    logic                     r_wr_bank;
    logic                     r_rd_bank;
    logic [IDXW-1:0]          r_idx;
    logic                     r_out_valid;
    logic [WORDW-1:0]         r_out_d;
    logic                     r_out_last;
    logic                     r_overflow;
    logic [7:0]               r_frames_out;

    logic [WORDW-1:0]         w_din [NBINS];
    logic                     w_xfer;
    logic                     w_last_xfer;
    logic [DEPTH_BANKS-1:0]   w_full_freed;
    logic [DEPTH_BANKS-1:0]   w_full_nxt;
    logic                     w_cap;
    logic                     w_drop;
    logic                     w_rd_bank_nxt;
    logic [IDXW-1:0]          w_idx_nxt;
    logic                     w_load;
    logic [WORDW-1:0]         w_rd_word;

    assign w_din[0]  = fft_d0;
    assign w_din[1]  = fft_d1;
    assign w_din[2]  = fft_d2;
    assign w_din[3]  = fft_d3;
    assign w_din[4]  = fft_d4;
    assign w_din[5]  = fft_d5;
    assign w_din[6]  = fft_d6;
    assign w_din[7]  = fft_d7;
    assign w_din[8]  = fft_d8;
    assign w_din[9]  = fft_d9;
    assign w_din[10] = fft_d10;
    assign w_din[11] = fft_d11;
    assign w_din[12] = fft_d12;
    assign w_din[13] = fft_d13;
    assign w_din[14] = fft_d14;
    assign w_din[15] = fft_d15;

    // Bank bookkeeping, next-beat selection and stream FSM next state.
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_xfer        = r_out_valid & out_ready;
        w_last_xfer   = w_xfer & r_out_last;
        w_full_freed  = r_full;
        if (w_last_xfer) begin
            w_full_freed[r_rd_bank] = 1'b0;
        end
        w_cap         = fft_valid & ~w_full_freed[r_wr_bank];
        w_drop        = fft_valid & ~w_cap;
        w_full_nxt    = w_full_freed;
        if (w_cap) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        w_rd_bank_nxt = r_rd_bank ^ w_last_xfer;
        w_idx_nxt     = w_xfer ? r_idx + IDXW'(1) : r_idx;

        case (r_state)
            ST_IDLE: begin
                if (w_full_nxt[r_rd_bank]) begin
                    w_state_nxt = ST_SEND;
                    w_load      = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (w_full_nxt[w_rd_bank_nxt]) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A frame captured this cycle is not in the RAM yet, so forward it.
        if (w_cap && (r_wr_bank == w_rd_bank_nxt)) begin
            w_rd_word = w_din[w_idx_nxt];
        end else begin
            w_rd_word = r_mem[w_rd_bank_nxt][w_idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_idx        <= '0;
            r_out_valid  <= 1'b0;
            r_out_d      <= '0;
            r_out_last   <= 1'b0;
            r_overflow   <= 1'b0;
            r_frames_out <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_full       <= w_full_nxt;
            r_wr_bank    <= r_wr_bank ^ w_cap;
            r_rd_bank    <= w_rd_bank_nxt;
            r_idx        <= w_idx_nxt;
            r_out_valid  <= (w_state_nxt == ST_SEND);
            if (w_load) begin
                r_out_d    <= w_rd_word;
                r_out_last <= (w_idx_nxt == IDXW'(NBINS - 1));
            end else if (w_xfer) begin
                r_out_last <= 1'b0;
            end
            r_overflow   <= r_overflow | w_drop;
            r_frames_out <= r_frames_out + 8'(w_last_xfer);
        end
    end

    // Frame storage; contents are don't-care while the bank flag is clear.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int k = 0; k < NBINS; k++) begin
                r_mem[r_wr_bank][k] <= w_din[k];
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_d      = r_out_d;
    assign out_idx    = r_idx;
    assign out_last   = r_out_last;
    assign overflow   = r_overflow;
    assign frames_out = r_frames_out;

`ifdef FFT_SER_PEAK_EN
    logic signed [15:0] w_re;
    logic signed [15:0] w_im;
    logic signed [31:0] w_re_sq;
    logic signed [31:0] w_im_sq;
    logic [32:0]        w_mag;
    logic               w_better;
    logic [32:0]        r_pk_mag;
    logic [IDXW-1:0]    r_pk_idx;
    logic [IDXW-1:0]    r_peak_idx;
    logic               r_peak_valid;

    assign w_re     = r_out_d[31:16];
    assign w_im     = r_out_d[15:0];
    assign w_re_sq  = 32'(w_re) * 32'(w_re);
    assign w_im_sq  = 32'(w_im) * 32'(w_im);
    assign w_mag    = {1'b0, w_re_sq} + {1'b0, w_im_sq};
    // Strict compare keeps the lowest bin on ties; bin 0 always seeds the max.
    assign w_better = (r_idx == '0) || (w_mag > r_pk_mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pk_mag     <= '0;
            r_pk_idx     <= '0;
            r_peak_idx   <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak_valid <= w_last_xfer;
            if (w_xfer && w_better) begin
                r_pk_mag <= w_mag;
                r_pk_idx <= r_idx;
            end
            if (w_last_xfer) begin
                r_peak_idx <= w_better ? r_idx : r_pk_idx;
            end
        end
    end

    assign peak_idx   = r_peak_idx;
    assign peak_valid = r_peak_valid;
`endif

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Self-checking bench for fft_frame_serializer: directed test-plan cases plus random traffic
// compared every cycle against a frame-queue reference model.
module tb_fft_frame_serializer;

    typedef logic [511:0] frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fft_valid;
    logic        out_ready;
    logic [31:0] fd [16];
    logic        out_valid;
    logic [31:0] out_d;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        overflow;
    logic [7:0]  frames_out;
`ifdef FFT_SER_PEAK_EN
    logic [3:0]  peak_idx;
    logic        peak_valid;
`endif

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    fft_frame_serializer #(.DEPTH_BANKS(2)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(fd[0]),   .fft_d1(fd[1]),   .fft_d2(fd[2]),   .fft_d3(fd[3]),
        .fft_d4(fd[4]),   .fft_d5(fd[5]),   .fft_d6(fd[6]),   .fft_d7(fd[7]),
        .fft_d8(fd[8]),   .fft_d9(fd[9]),   .fft_d10(fd[10]), .fft_d11(fd[11]),
        .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
        .out_ready(out_ready), .out_valid(out_valid), .out_d(out_d),
        .out_idx(out_idx), .out_last(out_last), .overflow(overflow),
        .frames_out(frames_out)
`ifdef FFT_SER_PEAK_EN
        , .peak_idx(peak_idx), .peak_valid(peak_valid)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of accepted frames, at most two outstanding.
    frame_t     mq[$];
    int         mpos;
    logic       movf;
    logic [7:0] mframes;
    logic       mpk_v;
    logic [3:0] mpk_idx;

    function automatic logic [32:0] mag(input logic [31:0] w);
        longint re;
        longint im;
        re = longint'($signed(w[31:16]));
        im = longint'($signed(w[15:0]));
        return 33'(re * re + im * im);
    endfunction

    function automatic logic [3:0] peak_of(input frame_t f);
        logic [3:0]  best = 4'd0;
        logic [32:0] bm   = mag(f[31:0]);
        for (int k = 1; k < 16; k++) begin
            if (mag(f[k*32 +: 32]) > bm) begin
                bm   = mag(f[k*32 +: 32]);
                best = 4'(k);
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin : model
        frame_t inf;
        bit     xfer;
        for (int k = 0; k < 16; k++) inf[k*32 +: 32] = fd[k];
        if (rst) begin
            mq.delete();
            mpos    = 0;
            movf    = 1'b0;
            mframes = 8'd0;
            mpk_v   = 1'b0;
            mpk_idx = 4'd0;
        end else begin
            xfer  = (mq.size() > 0) && out_ready;
            mpk_v = 1'b0;
            if (xfer) begin
                if (mpos == 15) begin
                    mpk_idx = peak_of(mq[0]);
                    mpk_v   = 1'b1;
                    void'(mq.pop_front());
                    mpos    = 0;
                    mframes = mframes + 8'd1;
                end else begin
                    mpos++;
                end
            end
            if (fft_valid) begin
                if (mq.size() < 2) mq.push_back(inf);
                else movf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        if (mon_en) begin
            chk("out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("out_d", out_d, mq[0][mpos*32 +: 32]);
                chk("out_idx", out_idx, mpos);
                chk("out_last", out_last, mpos == 15);
            end
            chk("overflow", overflow, movf);
            chk("frames_out", frames_out, mframes);
`ifdef FFT_SER_PEAK_EN
            chk("peak_valid", peak_valid, mpk_v);
            chk("peak_idx", peak_idx, mpk_idx);
`endif
        end
    end

    task automatic send(input frame_t f);
        for (int k = 0; k < 16; k++) fd[k] = f[k*32 +: 32];
        fft_valid = 1'b1;
        @(negedge clk);
        fft_valid = 1'b0;
    endtask

    function automatic frame_t rand_frame(input bit tiny);
        frame_t f;
        logic [31:0] pool [4];
        pool[0] = 32'h0000_0000; pool[1] = 32'h0001_0000;
        pool[2] = 32'h0000_FFFF; pool[3] = 32'h8000_0000;
        for (int k = 0; k < 16; k++) begin
            f[k*32 +: 32] = tiny ? pool[$urandom_range(0, 3)] : 32'($urandom);
        end
        return f;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_d"}, out_d, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_frames"}, frames_out, 0);
`ifdef FFT_SER_PEAK_EN
        chk({tag, "_pkidx"}, peak_idx, 0);
        chk({tag, "_pkv"}, peak_valid, 0);
`endif
    endtask

    initial begin
        frame_t f;
        bit     reached;
        rst       = 1'b1;
        fft_valid = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) fd[k] = 32'h0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk_zero("reset");
        rst = 1'b0;

        // Single frame with ready held high: bins 0..15 on consecutive cycles.
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 16; k++) f[k*32 +: 32] = {16'(k), 16'(32'h8000 + k)};
        send(f);
        for (int k = 0; k < 16; k++) begin
            chk("t1_valid", out_valid, 1);
            chk("t1_idx", out_idx, k);
            chk("t1_d", out_d, {16'(k), 16'(32'h8000 + k)});
            chk("t1_last", out_last, k == 15);
            @(negedge clk);
        end
        chk("t1_idle", out_valid, 0);
        chk("t1_frames", frames_out, 1);

        // Back-pressure pattern 1,0,0,1.
        send(rand_frame(1'b0));
        for (int c = 0; c < 80; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            @(negedge clk);
        end
        chk("t2_frames", frames_out, 2);

        pulse_reset();
        chk_zero("rst2");

        // Overflow: three frames while stalled, the third is dropped.
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            send(rand_frame(1'b0));
            @(negedge clk);
        end
        chk("t3_ovf", overflow, 1);
        out_ready = 1'b1;
        repeat (36) @(negedge clk);
        chk("t3_frames", frames_out, 2);
        chk("t3_idle", out_valid, 0);

        // New frame coincident with bin-15 transfer of the first of two queued frames.
        pulse_reset();
        out_ready = 1'b0;
        send(rand_frame(1'b0));
        send(rand_frame(1'b0));
        out_ready = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (out_valid && out_idx == 4'd15) reached = 1'b1;
            else @(negedge clk);
        end
        chk("t4_reach_bin15", reached, 1);
        send(rand_frame(1'b0));
        repeat (40) @(negedge clk);
        chk("t4_ovf", overflow, 0);
        chk("t4_frames", frames_out, 3);

        // Reset while beat 7 is presented.
        send(rand_frame(1'b0));
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (out_valid && out_idx == 4'd7) reached = 1'b1;
            else @(negedge clk);
        end
        chk("t5_reach_bin7", reached, 1);
        pulse_reset();
        chk_zero("t5");
        f = rand_frame(1'b0);
        send(f);
        chk("t5_restart_valid", out_valid, 1);
        chk("t5_restart_idx", out_idx, 0);
        chk("t5_restart_d", out_d, f[31:0]);
        repeat (20) @(negedge clk);

        // Peak: equal magnitude on bins 1 and 15, lowest wins.
        pulse_reset();
        f = '0;
        f[1*32 +: 32]  = 32'h0100_0000;
        f[15*32 +: 32] = 32'h0000_FF00;
        chk("model_peak_tie", peak_of(f), 1);
        chk("model_mag", mag(32'h0000_FF00), 33'd65536);
        send(f);
        repeat (20) @(negedge clk);
`ifdef FFT_SER_PEAK_EN
        chk("t6_peak_idx", peak_idx, 1);
`endif

        // Random traffic, stalls and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 11) == 0) begin
                f = rand_frame($urandom_range(0, 3) == 0);
                for (int k = 0; k < 16; k++) fd[k] = f[k*32 +: 32];
                fft_valid = 1'b1;
            end else begin
                fft_valid = 1'b0;
            end
            @(negedge clk);
        end
        rst       = 1'b0;
        fft_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("drain_idle", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Consumer-side endpoint for the FAS FFT output interface. It captures each 16-bin parallel frame presented on `fft_valid`/`fft_d0..fft_d15` into a two-bank ping-pong buffer. It then replays the frame one bin per beat over a valid/ready stream toward downstream storage or a host link. It sits directly behind the FAS core, in the same clock domain.

## Interface
- `DEPTH_BANKS` — 2 — number of frame banks. Fixed at 2; any other value is unsupported.
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `fft_valid` in 1 — one-cycle pulse; `fft_d0..fft_d15` are valid this cycle.
- `fft_d0` … `fft_d15` in 32 each — bin k: `[31:16]` signed real, `[15:0]` signed imag.
- `out_ready` in 1 — downstream accepts a beat.
- `out_valid` out 1 — beat available.
- `out_d` out 32 — bin word, bit-exact copy of the captured input.
- `out_idx` out 4 — bin index, 0..15.
- `out_last` out 1 — high on the bin-15 beat.
- `overflow` out 1 — sticky; a frame was dropped.
- `frames_out` out 8 — count of fully transferred frames; wraps 255→0.
- `peak_idx` out 4 — present only with `FFT_SER_PEAK_EN`.
- `peak_valid` out 1 — present only with `FFT_SER_PEAK_EN`.

## Operation
- **Storage:** two banks of 16×32-bit words. Each bank has a full flag.
- **Write pointer (`wr_bank`)** selects the bank for the next capture. **Read pointer (`rd_bank`)** selects the bank being streamed.
- **Capture:** on `fft_valid`, if the bank at `wr_bank` is free, all 16 words are written in that cycle. That bank's flag is set and `wr_bank` toggles.
- **Same-cycle free:** a bank counts as free if its last beat (`out_valid && out_ready && out_last`) transfers in the same cycle as the capture.
- **Drop:** if `fft_valid` arrives while both banks are full and no last beat transfers that cycle, the frame is discarded. `overflow` is set to 1 and stays set until `rst`. Buffer contents are untouched.
- **Stream FSM states:**
  - IDLE: `out_valid`=0. Go to SEND when the bank at `rd_bank` is full.
  - SEND: presents `bank[rd_bank][idx]`. On transfer, `idx` increments.
  - At `idx`=15, on transfer: clear that bank's flag, toggle `rd_bank`, increment `frames_out`, reset `idx` to 0. Then go to SEND if the other bank is full, otherwise to IDLE.
- **Order:** bins are sent 0..15 (`fft_d0` first). `out_idx` equals the bin number and `out_last` = (`out_idx`==15).
- **Back-pressure:** while `out_valid && !out_ready`, `out_d`, `out_idx` and `out_last` hold stable. `out_valid` never drops without a transfer.
- **Reset mid-operation:** all frames are discarded, both flags cleared, both pointers set to 0, FSM set to IDLE.

## Timing
- **Reset values:** `out_valid`=0, `out_d`=0, `out_idx`=0, `out_last`=0, `overflow`=0, `frames_out`=0, `peak_idx`=0, `peak_valid`=0.
- **Latency:** with the buffer empty, a capture in cycle N gives `out_valid`=1 with bin 0 in cycle N+1 (all outputs registered).
- **Throughput:** with `out_ready` held high, one beat per cycle. The first frame occupies cycles N+1..N+16.
- **Back-to-back frames:** with both banks full, the next frame's bin 0 follows bin 15 with no gap cycle.
- **Minimum frame spacing:** frames spaced ≥16 cycles apart with constant `out_ready`=1 never overflow.

## Configuration
- **`FFT_SER_PEAK_EN` defined:**
  - Each beat's magnitude re²+im² is computed as a 33-bit unsigned value from the signed 16-bit halves.
  - A running max is kept per frame. On ties the lowest index is kept.
  - One cycle after the `out_last` transfer, `peak_idx` holds the peak bin and `peak_valid` pulses for 1 cycle.
  - `peak_idx` holds its value until the next frame's pulse.
- **`FFT_SER_PEAK_EN` undefined:** the ports and logic are absent. All other behaviour is identical.

## Test plan
- **Single frame, `out_ready`=1:** `fft_d`k = {k, 16'h8000+k} at cycle 10 → beats at cycles 11..26 with `out_idx`=k and `out_d` matching; `out_last` only at cycle 26; `frames_out`=1.
- **Back-pressure:** toggle `out_ready` 1,0,0,1 repeatedly → 16 beats in order, no duplicates, `out_d` stable while stalled, `frames_out`=1.
- **Overflow:** `out_ready`=0, three `fft_valid` pulses with frames A, B, C → `overflow`=1. Then raise `out_ready` → exactly A then B (32 beats, no gap), C absent, `frames_out`=2.
- **Same-cycle free:** both banks full, `fft_valid` coincident with A's bin-15 transfer → frame accepted, `overflow` stays 0, stream is A, B, new frame.
- **Reset mid-frame:** `rst` at beat 7 → next cycle all outputs 0. A new frame after reset streams from bin 0.
- **Peak (`FFT_SER_PEAK_EN`):** bin 1 = {16'h0100, 0}, bin 15 = {0, 16'hFF00}, others 0 → `peak_idx`=1 (tie broken low), `peak_valid` one cycle after `out_last`.
